// File: rtl/cmp_branch_unit.sv
// Compare-and-branch unit: owns the fetch PC, resolves one branch request per cycle
// and holds a multi-cycle flush after a redirect. Optional counters: CMP_BRANCH_STATS_EN.
module cmp_branch_unit #(
    parameter int                 DATA_W       = 8,
    parameter int                 ADDR_W       = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int                 FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        mode,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] inp1,
    input  logic [DATA_W-1:0] inp2,
    input  logic [ADDR_W-1:0] inst_pc,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic              result_valid,
    output logic              flush
`ifdef CMP_BRANCH_STATS_EN
    ,
    output logic [15:0]       br_count,
    output logic [15:0]       taken_count
`endif
);

    // state    | meaning
    // ST_RUN   | normal fetch, requests accepted when not stalled
    // ST_FLUSH | redirect in progress, pc holds target, requests ignored
    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              taken_q, taken_d;
    logic              rv_q, rv_d;

    logic              accept;
    logic              lt, gt, eq, cond;
    logic [ADDR_W-1:0] rel_tgt, jr_tgt, target;

    if (DATA_W >= ADDR_W) begin : g_jr_trunc
        assign jr_tgt = inp1[ADDR_W-1:0];
    end else begin : g_jr_zext
        assign jr_tgt = {{(ADDR_W-DATA_W){1'b0}}, inp1};
    end

    assign rel_tgt = inst_pc + offset;
    assign target  = (mode == 3'b111) ? jr_tgt : rel_tgt;

    assign lt = is_signed ? ($signed(inp1) < $signed(inp2)) : (inp1 < inp2);
    assign gt = is_signed ? ($signed(inp1) > $signed(inp2)) : (inp1 > inp2);
    assign eq = (inp1 == inp2);

    always_comb begin
        cond = 1'b0;
        case (mode)
            3'b000:  cond = lt;
            3'b001:  cond = gt;
            3'b010:  cond = eq;
            3'b011:  cond = !lt;
            3'b100:  cond = !gt;
            3'b101:  cond = !eq;
            default: cond = 1'b1;
        endcase
    end

    assign in_ready = (state_q == ST_RUN) && !stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        rv_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    rv_d = 1'b1;
                    if (cond) begin
                        taken_d = 1'b1;
                        pc_d    = target;
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                // counter runs through stalls so the flush length is fixed
                if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            rv_q    <= rv_d;
        end
    end

    assign pc           = pc_q;
    assign taken        = taken_q;
    assign result_valid = rv_q;
    assign flush        = (state_q == ST_FLUSH);

`ifdef CMP_BRANCH_STATS_EN
    logic [15:0] br_q, tk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_q <= 16'd0;
            tk_q <= 16'd0;
        end else begin
            if (rv_d && br_q != 16'hFFFF) br_q <= br_q + 16'd1;
            if (taken_d && tk_q != 16'hFFFF) tk_q <= tk_q + 16'd1;
        end
    end

    assign br_count    = br_q;
    assign taken_count = tk_q;
`endif

endmodule

// File: tb/tb_cmp_branch_unit.sv
// Bench for cmp_branch_unit: vector table, hand sequences and a randomized run
// against a cycle-level reference model. Built with FLUSH_CYCLES=3.
module tb_cmp_branch_unit;

    localparam int FC = 3;

    logic       clk = 1'b0;
    logic       rst, stall, in_valid, is_signed;
    logic [2:0] mode;
    logic [7:0] inp1, inp2, inst_pc, offset;
    logic       in_ready, taken, result_valid, flush;
    logic [7:0] pc;
`ifdef CMP_BRANCH_STATS_EN
    logic [15:0] br_count, taken_count;
`endif

    cmp_branch_unit #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .is_signed(is_signed), .inp1(inp1), .inp2(inp2),
        .inst_pc(inst_pc), .offset(offset), .pc(pc), .taken(taken),
        .result_valid(result_valid), .flush(flush)
`ifdef CMP_BRANCH_STATS_EN
        , .br_count(br_count), .taken_count(taken_count)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference model: pc value, flush cycles still to come, last pulses, stats
    int m_pc, m_fl, m_br, m_tk;
    bit m_taken, m_rv;

    typedef struct {
        logic [2:0] mode;
        logic       sgn;
        logic [7:0] a, b, ipc, off;
        bit         exp_taken;
        logic [7:0] exp_tgt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int sval(input int v, input bit sgn);
        return (sgn && v >= 128) ? v - 256 : v;
    endfunction

    function automatic bit ref_cond(input int md, input bit sgn, input int a, input int b);
        int x = sval(a, sgn);
        int y = sval(b, sgn);
        case (md)
            0: return x < y;
            1: return x > y;
            2: return a == b;
            3: return x >= y;
            4: return x <= y;
            5: return a != b;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_fl = 0; m_br = 0; m_tk = 0; m_taken = 0; m_rv = 0;
    endtask

    task automatic drive(input bit iv, input bit st, input int md, input bit sg,
                         input int a, input int b, input int ipc, input int off);
        in_valid = iv; stall = st; mode = 3'(md); is_signed = sg;
        inp1 = 8'(a); inp2 = 8'(b); inst_pc = 8'(ipc); offset = 8'(off);
    endtask

    // one clock: check in_ready, advance model, check registered outputs
    task automatic cycle();
        bit rdy;
        #1;
        rdy = (m_fl == 0) && !stall;
        chk("in_ready", in_ready, rdy);
        m_taken = 0; m_rv = 0;
        if (m_fl > 0) begin
            m_fl--;
        end else if (in_valid && rdy) begin
            m_rv = 1;
            if (ref_cond(mode, is_signed, inp1, inp2)) begin
                m_taken = 1;
                m_pc = (mode == 3'd7) ? int'(inp1) : (int'(inst_pc) + int'(offset)) % 256;
                m_fl = FC;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end else if (!stall) begin
            m_pc = (m_pc + 1) % 256;
        end
        if (m_rv && m_br < 65535) m_br++;
        if (m_taken && m_tk < 65535) m_tk++;
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("taken", taken, m_taken);
        chk("result_valid", result_valid, m_rv);
        chk("flush", flush, m_fl > 0);
    endtask

    task automatic run_vec(input int i);
        int prev = m_pc;
        drive(1, 0, vecs[i].mode, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].ipc, vecs[i].off);
        cycle();
        chk($sformatf("vec%0d_taken", i), taken, vecs[i].exp_taken);
        chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_taken ? int'(vecs[i].exp_tgt) : (prev + 1) % 256);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (FC) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        int saved;
        vecs[0]  = '{3'b000, 1, 8'hFF, 8'h01, 8'h10, 8'hFC, 1, 8'h0C};
        vecs[1]  = '{3'b000, 0, 8'hFF, 8'h01, 8'h10, 8'hFC, 0, 8'h00};
        vecs[2]  = '{3'b001, 1, 8'hFF, 8'h01, 8'h10, 8'h04, 0, 8'h00};
        vecs[3]  = '{3'b001, 0, 8'hFF, 8'h01, 8'h10, 8'h04, 1, 8'h14};
        vecs[4]  = '{3'b010, 0, 8'h5A, 8'h5A, 8'h30, 8'h10, 1, 8'h40};
        vecs[5]  = '{3'b101, 1, 8'h5A, 8'h5A, 8'h30, 8'h10, 0, 8'h00};
        vecs[6]  = '{3'b011, 1, 8'h80, 8'h7F, 8'h20, 8'h02, 0, 8'h00};
        vecs[7]  = '{3'b011, 0, 8'h80, 8'h7F, 8'h20, 8'h02, 1, 8'h22};
        vecs[8]  = '{3'b100, 1, 8'h05, 8'h05, 8'h00, 8'h7F, 1, 8'h7F};
        vecs[9]  = '{3'b110, 0, 8'h00, 8'h00, 8'hF0, 8'h20, 1, 8'h10};
        vecs[10] = '{3'b111, 0, 8'h40, 8'h99, 8'h70, 8'h01, 1, 8'h40};
        vecs[11] = '{3'b101, 1, 8'h01, 8'h02, 8'h08, 8'hF8, 1, 8'h00};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        rst = 1'b1;
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_flush", flush, 0);
        chk("rst_taken", taken, 0);
        chk("rst_rv", result_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("count_pc", pc, i);
        end

        // wrap: jump to 0xFF, wait out the flush, next edge must give 0
        drive(1, 0, 6, 0, 0, 0, 8'hFF, 8'h00);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (FC) cycle();
        chk("pre_wrap_pc", pc, 8'hFF);
        cycle();
        chk("wrap_pc", pc, 0);

        for (int i = 0; i < 12; i++) run_vec(i);

        // JR with a 3-cycle flush: flush high and pc pinned while in_ready low
        drive(1, 0, 7, 0, 8'h40, 0, 8'h00, 8'h00);
        cycle();
        chk("jr_taken", taken, 1);
        for (int k = 0; k < FC; k++) begin
            chk("jr_flush", flush, 1);
            chk("jr_pc", pc, 8'h40);
            chk("jr_ready", in_ready, 0);
            if (k < FC - 1) cycle();
        end
        cycle();
        chk("jr_flush_drop", flush, 0);
        chk("jr_pc_after", pc, 8'h40);

        // stall: four cycles of a pending request, nothing accepted
        saved = m_pc;
        drive(1, 1, 6, 0, 0, 0, 8'h20, 8'h10);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("stall_pc", pc, saved);
            chk("stall_rv", result_valid, 0);
        end
        // accepted the cycle before stall rises: redirect still lands
        drive(1, 0, 6, 0, 0, 0, 8'h20, 8'h10);
        cycle();
        stall = 1'b1;
        in_valid = 1'b0;
        chk("late_stall_pc", pc, 8'h30);
        repeat (FC + 1) cycle();
        stall = 1'b0;
        cycle();

        // reset in the second flush cycle
        drive(1, 0, 2, 0, 8'h5A, 8'h5A, 8'h10, 8'h04);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("midflush_flush_before", flush, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midflush_pc", pc, 0);
        chk("midflush_flush", flush, 0);
        chk("midflush_ready", in_ready, 1);
        chk("midflush_taken", taken, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();
        chk("post_reset_pc", pc, 1);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            int a = $urandom_range(0, 255);
            int b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 255);
            drive($urandom_range(0, 1), $urandom_range(0, 4) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 1), a, b, $urandom_range(0, 255), $urandom_range(0, 255));
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (FC + 1) cycle();

`ifdef CMP_BRANCH_STATS_EN
        chk("rand_br_count", br_count, m_br);
        chk("rand_taken_count", taken_count, m_tk);
        do_reset();
        #1;
        chk("stats_rst_br", br_count, 0);
        for (int i = 0; i < 5; i++) run_vec(i);
        chk("stats_br_count", br_count, 5);
        chk("stats_taken_count", taken_count, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
